// File: rtl/inst_sram_port_arbiter.sv
// Two-port arbiter for the instruction SRAM data port: p0 = core fetch,
// p1 = AXI slave adapter. Ownership is held while responses are
// outstanding, grants are sticky up to BURST_LIMIT when the peer waits,
// and issue stops at MAX_OUTSTANDING unanswered requests.
// Ports: clk_i/reset_i; pN_data_* request/grant/response per port;
// mem_data_* SRAM side; owner_o, busy_o, resp_err_o status.
`timescale 1ns/1ps
module inst_sram_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BURST_LIMIT     = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    p0_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_data_addr_i,
  input  logic                    p0_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_data_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_data_wdata_i,
  output logic                    p0_data_gnt_o,
  output logic                    p0_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_data_rdata_o,
  input  logic                    p1_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   p1_data_addr_i,
  input  logic                    p1_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_data_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_data_wdata_i,
  output logic                    p1_data_gnt_o,
  output logic                    p1_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_data_rdata_o,
  output logic                    mem_data_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_data_addr_o,
  output logic                    mem_data_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_data_be_o,
  output logic [DATA_WIDTH-1:0]   mem_data_wdata_o,
  input  logic                    mem_data_gnt_i,
  input  logic                    mem_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_rdata_i,
  output logic                    owner_o,
  output logic                    busy_o,
  output logic                    resp_err_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BURST_LIMIT + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BL = BW'(BURST_LIMIT);

  logic          owner_q;
  logic [OW-1:0] outst_q;
  logic [BW-1:0] burst_q;

  logic          rsp_ok;
  logic [OW-1:0] eff;
  logic          sel;
  logic          sel_req;
  logic          accept;

  always_comb begin
    rsp_ok = mem_data_rvalid_i && (outst_q != '0) && !reset_i;
    eff    = outst_q - OW'(rsp_ok);
    sel    = owner_q;
    // Ownership is locked while anything remains unanswered, so every
    // response can be steered by owner_q alone.
    if (eff == '0) begin
      if (p0_data_req_i && !p1_data_req_i) begin
        sel = 1'b0;
      end else if (p1_data_req_i && !p0_data_req_i) begin
        sel = 1'b1;
      end else if (p0_data_req_i && p1_data_req_i) begin
        sel = (burst_q >= BL) ? !owner_q : owner_q;
      end
    end
    sel_req = sel ? p1_data_req_i : p0_data_req_i;
    mem_data_req_o = sel_req && (eff < MAX_O) && !reset_i;
    accept = mem_data_req_o && mem_data_gnt_i;
  end

  always_comb begin
    mem_data_addr_o  = p0_data_addr_i;
    mem_data_we_o    = p0_data_we_i;
    mem_data_be_o    = p0_data_be_i;
    mem_data_wdata_o = p0_data_wdata_i;
    if (sel) begin
      mem_data_addr_o  = p1_data_addr_i;
      mem_data_we_o    = p1_data_we_i;
      mem_data_be_o    = p1_data_be_i;
      mem_data_wdata_o = p1_data_wdata_i;
    end
  end

  always_comb begin
    p0_data_gnt_o    = accept && !sel;
    p1_data_gnt_o    = accept && sel;
    p0_data_rvalid_o = rsp_ok && !owner_q;
    p1_data_rvalid_o = rsp_ok && owner_q;
    p0_data_rdata_o  = mem_data_rdata_i;
    p1_data_rdata_o  = mem_data_rdata_i;
    resp_err_o       = mem_data_rvalid_i && (outst_q == '0) && !reset_i;
    busy_o           = (outst_q != '0);
    owner_o          = owner_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q <= 1'b0;
      outst_q <= '0;
      burst_q <= '0;
    end else begin
      outst_q <= eff + OW'(accept);
      if (accept) begin
        owner_q <= sel;
        if (sel == owner_q) begin
          burst_q <= (burst_q >= BL) ? BL : burst_q + BW'(1);
        end else begin
          burst_q <= BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_port_arbiter.sv
// Self-checking bench for inst_sram_port_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXO = 2;
  localparam int BLIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0 = 1'b0, r1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic w0 = 1'b0, w1 = 1'b0;
  logic [DW/8-1:0] b0 = '0, b1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic g0, g1, v0, v1;
  logic [DW-1:0] q0, q1;
  logic mreq, mwe;
  logic [AW-1:0] maddr;
  logic [DW/8-1:0] mbe;
  logic [DW-1:0] mwd;
  logic mgnt = 1'b0, mrv = 1'b0;
  logic [DW-1:0] mrd = '0;
  logic own_o, busy, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_sram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO), .BURST_LIMIT(BLIM)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .p0_data_req_i(r0), .p0_data_addr_i(a0), .p0_data_we_i(w0),
    .p0_data_be_i(b0), .p0_data_wdata_i(d0),
    .p0_data_gnt_o(g0), .p0_data_rvalid_o(v0), .p0_data_rdata_o(q0),
    .p1_data_req_i(r1), .p1_data_addr_i(a1), .p1_data_we_i(w1),
    .p1_data_be_i(b1), .p1_data_wdata_i(d1),
    .p1_data_gnt_o(g1), .p1_data_rvalid_o(v1), .p1_data_rdata_o(q1),
    .mem_data_req_o(mreq), .mem_data_addr_o(maddr), .mem_data_we_o(mwe),
    .mem_data_be_o(mbe), .mem_data_wdata_o(mwd),
    .mem_data_gnt_i(mgnt), .mem_data_rvalid_i(mrv), .mem_data_rdata_i(mrd),
    .owner_o(own_o), .busy_o(busy), .resp_err_o(err)
  );

  // Reference model: queue of ports whose requests await a response,
  // the port of the last grant, and the length of its current grant run.
  int m_q[$];
  int m_own = 0;
  int m_run = 0;
  int m_sel = 0;
  bit m_acc = 0;
  bit m_rok = 0;
  logic [7:0] exp_ctl;
  logic [132:0] exp_data;

  function automatic logic [7:0] obs();
    return {mreq, g0, g1, v0, v1, err, busy, own_o};
  endfunction

  function automatic logic [132:0] obs_data();
    return {maddr, mwe, mbe, mwd, q0, q1};
  endfunction

  function automatic void model_eval();
    int n;
    int eff;
    bit want;
    bit rvp;
    n = m_q.size();
    m_rok = mrv && n > 0 && !rst;
    eff = n - (m_rok ? 1 : 0);
    m_sel = m_own;
    if (eff == 0) begin
      if (r0 && !r1) m_sel = 0;
      else if (r1 && !r0) m_sel = 1;
      else if (r0 && r1 && m_run >= BLIM) m_sel = 1 - m_own;
    end
    want = (m_sel == 1) ? r1 : r0;
    want = want && eff < MAXO && !rst;
    m_acc = want && mgnt;
    rvp = (n > 0) ? (m_q[0] == 1) : 1'b0;
    exp_ctl = {want, m_acc && m_sel == 0, m_acc && m_sel == 1,
               m_rok && !rvp, m_rok && rvp,
               mrv && n == 0 && !rst, n != 0, m_own == 1};
    if (m_sel == 1) exp_data = {a1, w1, b1, d1, mrd, mrd};
    else exp_data = {a0, w0, b0, d0, mrd, mrd};
  endfunction

  task automatic drive(input logic rs, input logic p0, input logic p1,
                       input logic g, input logic rv);
    @(negedge clk);
    rst = rs; r0 = p0; r1 = p1; mgnt = g; mrv = rv;
    mrd = $urandom;
    #1;
    if (rst) begin
      m_q.delete();
      m_own = 0;
      m_run = 0;
    end
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (m_rok) void'(m_q.pop_front());
      if (m_acc) begin
        m_q.push_back(m_sel);
        if (m_sel == m_own) m_run = (m_run >= BLIM) ? BLIM : m_run + 1;
        else m_run = 1;
        m_own = m_sel;
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      tests++;
      if (obs() !== 8'h00) begin
        fails++;
        $display("FAIL reset c%0d ctl got %b want 00000000", i, obs());
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (obs() !== 8'h00) begin
        fails++;
        $display("FAIL idle c%0d ctl got %b want 00000000", i, obs());
      end
      tick();
    end
  endtask

  task automatic test_single_stream();
    logic [4:0] want_g0 = 5'b00111;
    logic [4:0] want_v0 = 5'b01110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a0 = AW'(i * 4);
      drive(1'b0, i < 3, 1'b0, 1'b1, i >= 1 && i <= 3);
      tests++;
      if ({g0, v0, g1, v1} !== {want_g0[i], want_v0[i], 2'b00} ||
          obs() !== exp_ctl) begin
        fails++;
        $display("FAIL stream c%0d ctl got %b want %b g0/v0 %b%b",
                 i, obs(), exp_ctl, want_g0[i], want_v0[i]);
      end
      if (i < 3) begin
        tests++;
        if (maddr !== AW'(i * 4)) begin
          fails++;
          $display("FAIL stream_addr c%0d got %h want %h", i, maddr, i * 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_fair_contention();
    logic [11:0] want_p1 = 12'b000011110000;
    bit prev = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, prev);
      prev = m_acc;
      tests++;
      if ({g0, g1} !== {!want_p1[i], want_p1[i]} || obs() !== exp_ctl) begin
        fails++;
        $display("FAIL fair c%0d ctl got %b want %b p1turn %b",
                 i, obs(), exp_ctl, want_p1[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, prev);
    tick();
  endtask

  task automatic test_ownership_lock();
    logic [4:0] p0r = 5'b00011;
    logic [4:0] p1r = 5'b11100;
    logic [4:0] rv  = 5'b11000;
    logic [4:0] want_g1 = 5'b10000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, p0r[i], p1r[i], 1'b1, rv[i]);
      tests++;
      if (g1 !== want_g1[i] || obs() !== exp_ctl) begin
        fails++;
        $display("FAIL lock c%0d ctl got %b want %b g1 want %b",
                 i, obs(), exp_ctl, want_g1[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_outstanding_cap();
    logic [4:0] rv = 5'b10000;
    logic [4:0] want_req = 5'b10011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, rv[i]);
      tests++;
      if (mreq !== want_req[i] || obs() !== exp_ctl) begin
        fails++;
        $display("FAIL cap c%0d ctl got %b want %b req want %b",
                 i, obs(), exp_ctl, want_req[i]);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_error_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({err, v0, v1} !== 3'b100 || obs() !== exp_ctl) begin
      fails++;
      $display("FAIL spurious ctl got %b want %b", obs(), exp_ctl);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse got %b want 0", err);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_two got %b want 1", busy);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tests++;
    if (obs() !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset ctl got %b want 00000000", obs());
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({err, v0, v1, busy} !== 4'b1000 || obs() !== exp_ctl) begin
      fails++;
      $display("FAIL late_rsp ctl got %b want %b", obs(), exp_ctl);
    end
    tick();
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    bit rv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!p0) begin
        p0 = ($urandom_range(0, 2) != 0);
        a0 = $urandom; w0 = 1'($urandom); b0 = 4'($urandom); d0 = $urandom;
      end
      if (!p1) begin
        p1 = ($urandom_range(0, 2) != 0);
        a1 = $urandom; w1 = 1'($urandom); b1 = 4'($urandom); d1 = $urandom;
      end
      if (m_q.size() > 0) rv = ($urandom_range(0, 1) != 0);
      else rv = ($urandom_range(0, 15) == 0);
      drive(1'b0, p0, p1, $urandom_range(0, 3) != 0, rv);
      tests++;
      if (obs() !== exp_ctl) begin
        fails++;
        $display("FAIL rand_ctl c%0d got %b want %b", i, obs(), exp_ctl);
      end
      tests++;
      if (obs_data() !== exp_data) begin
        fails++;
        $display("FAIL rand_data c%0d got %h want %h", i, obs_data(), exp_data);
      end
      if (exp_ctl[6]) p0 = 0;
      if (exp_ctl[5]) p1 = 0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_fair_contention();
    test_ownership_lock();
    test_outstanding_cap();
    test_error_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
